// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-to-1 round-robin arbitrated mux with a registered output.
// Optional packet lock enabled by RR_ARB_MUX_LOCK_EN (adds in_last/out_last).
module rr_arb_mux #(
    parameter int Bit_Width = 32,
    parameter int NUM_IN    = 4,
    parameter int SEL_W     = $clog2(NUM_IN)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_IN*Bit_Width-1:0] in_data,
    input  logic [NUM_IN-1:0]           in_valid,
    output logic [NUM_IN-1:0]           in_ready,
`ifdef RR_ARB_MUX_LOCK_EN
    input  logic [NUM_IN-1:0]           in_last,
    output logic                        out_last,
`endif
    output logic [Bit_Width-1:0]        out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SEL_W-1:0]            out_sel
);

    logic [SEL_W-1:0]     r_ptr;
    logic                 r_out_valid;
    logic [Bit_Width-1:0] r_out_data;
    logic [SEL_W-1:0]     r_out_sel;

    logic                 w_load_en;
    logic                 w_found;
    logic                 w_xfer;
    logic [SEL_W-1:0]     w_gidx;
    logic [SEL_W-1:0]     w_cand;
    logic [NUM_IN-1:0]    w_grant;
    logic [Bit_Width-1:0] w_ch [NUM_IN];

`ifdef RR_ARB_MUX_LOCK_EN
    logic                 r_lock;
    logic                 r_out_last;
`endif

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
        assign w_ch[gi] = in_data[gi*Bit_Width +: Bit_Width];
    end

    // Grant search: first valid channel after ptr, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_cand  = '0;
        w_grant = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            w_cand = SEL_W'((int'(r_ptr) + k) % NUM_IN);
            if (!w_found && in_valid[w_cand]) begin
                w_found = 1'b1;
                w_gidx  = w_cand;
            end
        end
`ifdef RR_ARB_MUX_LOCK_EN
        // A locked packet keeps the grant even across valid bubbles.
        if (r_lock) begin
            w_found = 1'b1;
            w_gidx  = r_ptr;
        end
`endif
        if (w_found) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    assign w_load_en = !r_out_valid || out_ready;
    assign in_ready  = w_grant & {NUM_IN{w_load_en & rst_n}};
    assign w_xfer    = |(in_ready & in_valid);

    // Output stage: load on accepted beat, clear valid on drain-to-empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= SEL_W'(NUM_IN - 1);
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_ch[w_gidx];
            r_out_sel   <= w_gidx;
            r_ptr       <= w_gidx;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef RR_ARB_MUX_LOCK_EN
    // Packet lock: held from a non-last beat until the last beat is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock     <= 1'b0;
            r_out_last <= 1'b0;
        end else if (w_xfer) begin
            r_lock     <= !in_last[w_gidx];
            r_out_last <= in_last[w_gidx];
        end
    end

    assign out_last = r_out_last;
`endif

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed vector table, hand sequences and a
// randomized run against a behavioural round-robin model.
module tb_rr_arb_mux;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_sel;
`ifdef RR_ARB_MUX_LOCK_EN
    logic [N-1:0]   in_last;
    logic           out_last;
`endif

    always #5 clk = ~clk;

    rr_arb_mux #(
        .Bit_Width(W),
        .NUM_IN   (N)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
`ifdef RR_ARB_MUX_LOCK_EN
        .in_last  (in_last),
        .out_last (out_last),
`endif
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sel  (out_sel)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [N-1:0]  iv;
        logic          ordy;
        logic [N-1:0]  rdy;
        logic          ov;
        logic [SW-1:0] sel;
        logic [W-1:0]  data;
    } vec_t;

    vec_t tbl[17];

    // behavioural model state
    logic [W-1:0] pd [N];
    logic         pv [N];
    int           seq [N];
    logic [W-1:0] sb [$];
    int           m_ptr;
    logic         m_ov;
    logic [W-1:0] m_data;
    int           m_sel;
    int           g;
    logic         ld;
    logic [N-1:0] exp_rdy;

    task automatic set_a0();
        in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        m_ov   = 1'b0;
        m_ptr  = N - 1;
        m_data = '0;
        m_sel  = 0;
    endtask

    initial begin
        // row: iv, out_ready, in_ready, out_valid, out_sel, out_data
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
        tbl[5]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
        tbl[6]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
        tbl[7]  = '{4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
        tbl[8]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
        tbl[9]  = '{4'b0110, 1'b0, 4'b0000, 1'b1, 2'd0, 32'hA0};
        tbl[10] = '{4'b0110, 1'b0, 4'b0000, 1'b1, 2'd0, 32'hA0};
        tbl[11] = '{4'b0110, 1'b0, 4'b0000, 1'b1, 2'd0, 32'hA0};
        tbl[12] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
        tbl[13] = '{4'b0110, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
        tbl[14] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};
        tbl[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 32'hA3};
        tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 32'hA3};

`ifdef RR_ARB_MUX_LOCK_EN
        in_last = '1;
`endif
        // reset held with all channels requesting
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        set_a0();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_sel", 64'(out_sel), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready),
                64'(tbl[i].rdy));
            @(negedge clk);
            chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid),
                64'(tbl[i].ov));
            chk($sformatf("tbl%0d_out_sel", i), 64'(out_sel),
                64'(tbl[i].sel));
            chk($sformatf("tbl%0d_out_data", i), 64'(out_data),
                64'(tbl[i].data));
        end

        // async reset while a beat is held under backpressure
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        @(negedge clk);
        chk("midrst_pre_valid", 64'(out_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_out_data", 64'(out_data), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = '0;
        @(negedge clk);
        chk("midrst_dropped", 64'(out_valid), 64'(0));

`ifdef RR_ARB_MUX_LOCK_EN
        begin
            logic [N-1:0] l_iv   [5] = '{4'b0110, 4'b0100, 4'b0110,
                                         4'b0110, 4'b0100};
            logic         l_last [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            logic [N-1:0] l_rdy  [5] = '{4'b0010, 4'b0010, 4'b0010,
                                         4'b0010, 4'b0100};
            logic         l_ov   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
            logic [1:0]   l_sel  [5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
            logic [W-1:0] l_dat  [5] = '{32'hB0, 32'hB0, 32'hB1,
                                         32'hB2, 32'hC2};
            logic         l_olst [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
            logic [W-1:0] l_d1   [5] = '{32'hB0, 32'hB1, 32'hB1,
                                         32'hB2, 32'hB2};
            out_ready = 1'b1;
            for (int i = 0; i < 5; i++) begin
                in_valid         = l_iv[i];
                in_last          = '1;
                in_last[1]       = l_last[i];
                in_data[1*W +: W] = l_d1[i];
                in_data[2*W +: W] = 32'hC2;
                #1;
                chk($sformatf("lock%0d_in_ready", i), 64'(in_ready),
                    64'(l_rdy[i]));
                @(negedge clk);
                chk($sformatf("lock%0d_out_valid", i), 64'(out_valid),
                    64'(l_ov[i]));
                chk($sformatf("lock%0d_out_sel", i), 64'(out_sel),
                    64'(l_sel[i]));
                chk($sformatf("lock%0d_out_data", i), 64'(out_data),
                    64'(l_dat[i]));
                chk($sformatf("lock%0d_out_last", i), 64'(out_last),
                    64'(l_olst[i]));
            end
            in_last = '1;
        end
`endif

        // randomized producers against the behavioural model
        do_reset();
        for (int c = 0; c < N; c++) begin
            pv[c]  = 1'b0;
            pd[c]  = '0;
            seq[c] = 0;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (!pv[c] && $urandom_range(1, 0) == 1) begin
                    pv[c] = 1'b1;
                    pd[c] = (32'(c) << 28) | 32'(seq[c]);
                end
                in_valid[c]    = pv[c];
                in_data[c*W +: W] = pd[c];
            end
            out_ready = ($urandom_range(9, 0) < 7);
            #1;
            ld = !m_ov || out_ready;
            g  = -1;
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && pv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            exp_rdy = '0;
            if (g >= 0 && ld) exp_rdy[g] = 1'b1;
            chk("rnd_in_ready", 64'(in_ready), 64'(exp_rdy));
            if (m_ov && out_ready) begin
                if (sb.size() == 0) begin
                    chk("rnd_sb_empty", 64'(1), 64'(0));
                end else begin
                    chk("rnd_sb_data", 64'(out_data), 64'(sb.pop_front()));
                end
            end
            if (g >= 0 && ld) begin
                sb.push_back(pd[g]);
                m_ov   = 1'b1;
                m_data = pd[g];
                m_sel  = g;
                m_ptr  = g;
                pv[g]  = 1'b0;
                seq[g]++;
            end else if (ld && m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            @(negedge clk);
            chk("rnd_out_valid", 64'(out_valid), 64'(m_ov));
            chk("rnd_out_sel", 64'(out_sel), 64'(m_sel));
            chk("rnd_out_data", 64'(out_data), 64'(m_data));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
